// File: rtl/perceptron_train_ctrl.sv
// Control FSM for an N-sample perceptron trainer: runs epochs until an error-free epoch, then streams test inputs.
// Optional epoch limit is enabled by defining PCTRL_TIMEOUT_EN.
module perceptron_train_ctrl #(
  parameter int N_SAMPLES  = 4,
  parameter int ADDR_W     = 2,
  parameter int MAX_EPOCHS = 16,
  parameter int EPOCH_W    = 5,
  parameter int TADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               retrain,
  input  logic               eq,
  input  logic               EOI,
  output logic [ADDR_W-1:0]  sample_addr,
  output logic [TADDR_W-1:0] test_addr,
  output logic               clrW,
  output logic               ldX,
  output logic               ldT,
  output logic               ldW,
  output logic               ldB,
  output logic               updating,
  output logic               learned,
  output logic               timeout,
  output logic               busy,
  output logic               res_valid,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [ADDR_W:0]    err_cnt
);

  if (N_SAMPLES < 1 || N_SAMPLES > 2**ADDR_W) begin : g_bad_n_samples
    $error("N_SAMPLES must lie in 1..2**ADDR_W");
  end
  if (MAX_EPOCHS >= 2**EPOCH_W) begin : g_bad_epoch_w
    $error("EPOCH_W too narrow for MAX_EPOCHS");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EPOCH_START, S_FETCH, S_EVAL, S_UPDATE, S_EPOCH_END, S_TEST
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W+1)'(N_SAMPLES);
`ifdef PCTRL_TIMEOUT_EN
  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);
`endif

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    sample_addr_q, sample_addr_d;
  logic [TADDR_W-1:0]   test_addr_q, test_addr_d;
  logic [EPOCH_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic [ADDR_W:0]      err_cnt_q, err_cnt_d;
  logic                 learned_q, learned_d;
  logic                 timeout_q, timeout_d;
  logic                 res_valid_q, res_valid_d;
  logic                 done_q, done_d;
  logic                 last_sample;
  logic [EPOCH_W-1:0]   epoch_inc;

  assign last_sample = (sample_addr_q == LAST_ADDR);
  assign epoch_inc   = epoch_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    sample_addr_d = sample_addr_q;
    test_addr_d   = test_addr_q;
    epoch_cnt_d   = epoch_cnt_q;
    err_cnt_d     = err_cnt_q;
    learned_d     = learned_q;
    timeout_d     = timeout_q;
    done_d        = 1'b0;
    clrW          = 1'b0;
    ldX           = 1'b0;
    ldT           = 1'b0;
    ldW           = 1'b0;
    ldB           = 1'b0;
    updating      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (learned_q && !retrain) begin
            state_d     = S_TEST;
            test_addr_d = '0;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        clrW        = 1'b1;
        epoch_cnt_d = '0;
        learned_d   = 1'b0;
        timeout_d   = 1'b0;
        state_d     = S_EPOCH_START;
      end
      S_EPOCH_START: begin
        sample_addr_d = '0;
        err_cnt_d     = '0;
        state_d       = S_FETCH;
      end
      S_FETCH: begin
        ldX     = 1'b1;
        ldT     = 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        updating = ~eq;
        if (!eq) begin
          state_d = S_UPDATE;
        end else if (last_sample) begin
          state_d = S_EPOCH_END;
        end else begin
          sample_addr_d = sample_addr_q + 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_UPDATE: begin
        ldW      = 1'b1;
        ldB      = 1'b1;
        updating = 1'b1;
        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (last_sample) begin
          state_d = S_EPOCH_END;
        end else begin
          sample_addr_d = sample_addr_q + 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_EPOCH_END: begin
        epoch_cnt_d = epoch_inc;
        if (err_cnt_q == '0) begin
          learned_d   = 1'b1;
          test_addr_d = '0;
          state_d     = S_TEST;
        end
`ifdef PCTRL_TIMEOUT_EN
        else if (epoch_inc == EPOCH_LIMIT) begin
          // Give up: report the abort and skip the test phase entirely.
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
`endif
        else begin
          state_d = S_EPOCH_START;
        end
      end
      S_TEST: begin
        ldX         = 1'b1;
        test_addr_d = test_addr_q + 1'b1;
        if (EOI) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    res_valid_d = ldX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sample_addr_q <= '0;
      test_addr_q   <= '0;
      epoch_cnt_q   <= '0;
      err_cnt_q     <= '0;
      learned_q     <= 1'b0;
      timeout_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_addr_q <= sample_addr_d;
      test_addr_q   <= test_addr_d;
      epoch_cnt_q   <= epoch_cnt_d;
      err_cnt_q     <= err_cnt_d;
      learned_q     <= learned_d;
      timeout_q     <= timeout_d;
      res_valid_q   <= res_valid_d;
      done_q        <= done_d;
    end
  end

  assign sample_addr = sample_addr_q;
  assign test_addr   = test_addr_q;
  assign epoch_cnt   = epoch_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign learned     = learned_q;
  assign timeout     = timeout_q;
  assign res_valid   = res_valid_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);

endmodule
